// File: rtl/wb_initiator.sv
// wb_initiator: single-outstanding Wishbone classic-cycle master.
// Turns a valid/ready command stream into one bus cycle at a time and
// returns the result on a valid/ready response stream.
// Optional bus-hang protection is built when WB_INITIATOR_TIMEOUT_EN is
// defined. Without it, BUS waits indefinitely and rsp_tmo_o is tied to 0.
module wb_initiator #(
    parameter int unsigned AW          = 4,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    // command stream
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic          cmd_we_i,
    input  logic [AW-1:0] cmd_adr_i,
    input  logic [31:0]   cmd_dat_i,
    input  logic [3:0]    cmd_sel_i,
    // response stream
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [31:0]   rsp_dat_o,
    output logic          rsp_err_o,
    output logic          rsp_tmo_o,
    // Wishbone initiator side
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic          wb_we_o,
    output logic [AW-1:0] wb_adr_o,
    output logic [31:0]   wb_dat_o,
    output logic [3:0]    wb_sel_o,
    input  logic [31:0]   wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // Counter value on the last BUS cycle before the timeout fires: the
    // counter starts at 0 on the first BUS cycle.
    localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_CYC - 1);

    state_e        state_q;
    logic          wb_cyc_q;
    logic          wb_stb_q;
    logic          wb_we_q;
    logic [AW-1:0] wb_adr_q;
    logic [31:0]   wb_dat_q;
    logic [3:0]    wb_sel_q;
    logic          rsp_valid_q;
    logic [31:0]   rsp_dat_q;
    logic          rsp_err_q;
    logic          rsp_tmo_q;
    logic          tmo_hit;
    logic          term;

`ifdef WB_INITIATOR_TIMEOUT_EN
    logic [15:0]   cnt_q;

    // Timeout only when the slave stays silent; ack/err on the same edge win.
    always_comb begin
        tmo_hit = (cnt_q == TMO_LIM) && !wb_ack_i && !wb_err_i;
    end
`else
    logic          unused_tmo_lim;

    // No hang protection: the limit is deliberately unused.
    always_comb begin
        tmo_hit        = 1'b0;
        unused_tmo_lim = ^TMO_LIM;
    end
`endif

    // Any termination source ends the bus cycle.
    always_comb begin
        term = wb_ack_i || wb_err_i || tmo_hit;
    end

    assign cmd_ready_o = (state_q == S_IDLE);
    assign wb_cyc_o    = wb_cyc_q;
    assign wb_stb_o    = wb_stb_q;
    assign wb_we_o     = wb_we_q;
    assign wb_adr_o    = wb_adr_q;
    assign wb_dat_o    = wb_dat_q;
    assign wb_sel_o    = wb_sel_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_tmo_o   = rsp_tmo_q;

    // Transaction FSM with all bus and response outputs registered.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= S_IDLE;
            wb_cyc_q    <= 1'b0;
            wb_stb_q    <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_adr_q    <= '0;
            wb_dat_q    <= '0;
            wb_sel_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            rsp_tmo_q   <= 1'b0;
`ifdef WB_INITIATOR_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        state_q  <= S_BUS;
                        wb_cyc_q <= 1'b1;
                        wb_stb_q <= 1'b1;
                        wb_we_q  <= cmd_we_i;
                        wb_adr_q <= cmd_adr_i;
                        // Data lines stay quiet during reads.
                        wb_dat_q <= cmd_we_i ? cmd_dat_i : 32'h0;
                        wb_sel_q <= cmd_sel_i;
`ifdef WB_INITIATOR_TIMEOUT_EN
                        cnt_q    <= '0;
`endif
                    end
                end
                S_BUS: begin
                    if (term) begin
                        state_q     <= S_RESP;
                        wb_cyc_q    <= 1'b0;
                        wb_stb_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= wb_err_i || tmo_hit;
                        rsp_tmo_q   <= tmo_hit;
                        // Data only from a clean read ack; err beats ack.
                        rsp_dat_q   <= (wb_ack_i && !wb_err_i && !wb_we_q) ?
                                       wb_dat_i : 32'h0;
                    end else begin
`ifdef WB_INITIATOR_TIMEOUT_EN
                        cnt_q <= cnt_q + 16'd1;
`endif
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_initiator.sv
// Self-checking bench for wb_initiator: directed transactions against a
// negedge-driven Wishbone slave, a transaction-level reference model and a
// per-cycle compare process, plus literal checks of the listed scenarios.
module tb_wb_initiator;

    localparam int AW   = 4;
    localparam int TCYC = 8;
`ifdef WB_INITIATOR_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [AW-1:0] cmd_adr = '0;
    logic [31:0]   cmd_dat = '0;
    logic [3:0]    cmd_sel = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_dat;
    logic          rsp_err;
    logic          rsp_tmo;
    logic          wb_cyc, wb_stb, wb_we;
    logic [AW-1:0] wb_adr;
    logic [31:0]   wb_dat_o;
    logic [3:0]    wb_sel;
    logic [31:0]   wb_dat_i = '0;
    logic          wb_ack = 1'b0;
    logic          wb_err = 1'b0;

    int n_total = 0;
    int n_bad   = 0;

    wb_initiator #(.AW(AW), .TIMEOUT_CYC(TCYC)) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_we_i   (cmd_we),
        .cmd_adr_i  (cmd_adr),
        .cmd_dat_i  (cmd_dat),
        .cmd_sel_i  (cmd_sel),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_dat_o  (rsp_dat),
        .rsp_err_o  (rsp_err),
        .rsp_tmo_o  (rsp_tmo),
        .wb_cyc_o   (wb_cyc),
        .wb_stb_o   (wb_stb),
        .wb_we_o    (wb_we),
        .wb_adr_o   (wb_adr),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_o   (wb_sel),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack),
        .wb_err_i   (wb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- slave: 0=ack 1=err 2=ack+err 3=silent ----------------
    int          slv_mode  = 0;
    int          slv_wait  = 0;
    int          slv_cnt   = 0;
    logic [31:0] slv_rdata = '0;
    logic        slv_force_ack = 1'b0;

    initial forever begin
        @(negedge clk);
        if (wb_cyc === 1'b1 && wb_stb === 1'b1) begin
            if (slv_cnt >= slv_wait && slv_mode != 3) begin
                wb_ack   = slv_force_ack || slv_mode == 0 || slv_mode == 2;
                wb_err   = (slv_mode == 1 || slv_mode == 2);
                wb_dat_i = slv_rdata;
            end else begin
                wb_ack   = slv_force_ack;
                wb_err   = 1'b0;
                wb_dat_i = 32'hDEAD_BEEF;
            end
            slv_cnt++;
        end else begin
            slv_cnt  = 0;
            wb_ack   = slv_force_ack;
            wb_err   = 1'b0;
            wb_dat_i = 32'hDEAD_BEEF;
        end
    end

    // ---------------- bus monitor ----------------
    int          stb_cnt = 0;
    logic        last_we;
    logic [3:0]  last_adr;
    logic [31:0] last_dat;
    logic [3:0]  last_sel;

    initial forever begin
        @(negedge clk);
        if (wb_stb === 1'b1) begin
            stb_cnt++;
            last_we  = wb_we;
            last_adr = wb_adr;
            last_dat = wb_dat_o;
            last_sel = wb_sel;
        end
    end

    // ---------------- transaction-level reference model ----------------
    typedef struct {
        logic [31:0] dat;
        logic        err;
        logic        tmo;
    } rsp_t;

    rsp_t        m_q[$];
    logic        m_open = 1'b0;
    int          m_cycles = 0;
    logic        m_we = 1'b0;
    logic [3:0]  m_adr = '0;
    logic [31:0] m_dat = '0;
    logic [3:0]  m_sel = '0;
    rsp_t        m_r;
    logic        m_done;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_open   = 1'b0;
            m_cycles = 0;
            m_q.delete();
        end else if (m_q.size() != 0) begin
            if (rsp_ready) void'(m_q.pop_front());
        end else if (m_open) begin
            m_cycles++;
            m_done = 1'b1;
            if (wb_err)                              m_r = '{32'h0, 1'b1, 1'b0};
            else if (wb_ack)                         m_r = '{(m_we ? 32'h0 : wb_dat_i), 1'b0, 1'b0};
            else if (TMO_EN && m_cycles == TCYC)     m_r = '{32'h0, 1'b1, 1'b1};
            else                                     m_done = 1'b0;
            if (m_done) begin
                m_q.push_back(m_r);
                m_open = 1'b0;
            end
        end else if (cmd_valid) begin
            m_open   = 1'b1;
            m_cycles = 0;
            m_we     = cmd_we;
            m_adr    = cmd_adr;
            m_dat    = cmd_dat;
            m_sel    = cmd_sel;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, !m_open && m_q.size() == 0});
        chk("wb_cyc", {31'b0, wb_cyc}, {31'b0, m_open});
        chk("wb_stb", {31'b0, wb_stb}, {31'b0, m_open});
        if (m_open) begin
            chk("wb_we",  {31'b0, wb_we}, {31'b0, m_we});
            chk("wb_adr", {28'b0, wb_adr}, {28'b0, m_adr});
            chk("wb_dat_o", wb_dat_o, m_we ? m_dat : 32'h0);
            chk("wb_sel", {28'b0, wb_sel}, {28'b0, m_sel});
        end
        chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_q.size() != 0});
        if (m_q.size() != 0) begin
            chk("rsp_dat", rsp_dat, m_q[0].dat);
            chk("rsp_err", {31'b0, rsp_err}, {31'b0, m_q[0].err});
            chk("rsp_tmo", {31'b0, rsp_tmo}, {31'b0, m_q[0].tmo});
        end
        if (!TMO_EN) chk("tmo_tied", {31'b0, rsp_tmo}, 32'h0);
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue_cmd(input logic we, input logic [3:0] adr,
                             input logic [31:0] dat, input logic [3:0] sel);
        for (int i = 0; i < 50 && cmd_ready !== 1'b1; i++) @(negedge clk);
        chk("cmd_ready_wait", {31'b0, cmd_ready}, 32'h1);
        stb_cnt   = 0;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [31:0] d, output logic e, output logic t);
        for (int i = 0; i < 200 && rsp_valid !== 1'b1; i++) @(negedge clk);
        chk("rsp_seen", {31'b0, rsp_valid}, 32'h1);
        d = rsp_dat;
        e = rsp_err;
        t = rsp_tmo;
    endtask

    task automatic finish_rsp(input int hold, input logic [31:0] d);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bp_valid", {31'b0, rsp_valid}, 32'h1);
            chk("bp_dat", rsp_dat, d);
            chk("bp_cmd_ready", {31'b0, cmd_ready}, 32'h0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("ready_after_hs", {31'b0, cmd_ready}, 32'h1);
        chk("valid_after_hs", {31'b0, rsp_valid}, 32'h0);
    endtask

    // ---------------- directed scenarios ----------------
    logic [31:0] r_dat;
    logic        r_err, r_tmo;

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'h1);
        chk("rst_cyc", {31'b0, wb_cyc}, 32'h0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // zero-wait write
        slv_mode = 0; slv_wait = 0; slv_rdata = 32'h5555_AAAA;
        issue_cmd(1'b1, 4'h4, 32'h0000_00A5, 4'hF);
        wait_rsp(r_dat, r_err, r_tmo);
        chk("wr_stb_cycles", stb_cnt, 32'd1);
        chk("wr_we", {31'b0, last_we}, 32'h1);
        chk("wr_adr", {28'b0, last_adr}, 32'h4);
        chk("wr_dat", last_dat, 32'h0000_00A5);
        chk("wr_sel", {28'b0, last_sel}, 32'hF);
        chk("wr_rsp_dat", r_dat, 32'h0);
        chk("wr_rsp_err", {31'b0, r_err}, 32'h0);
        finish_rsp(0, r_dat);

        // read with three wait states
        slv_mode = 0; slv_wait = 3; slv_rdata = 32'h0012_3456;
        issue_cmd(1'b0, 4'h0, 32'hFFFF_FFFF, 4'hF);
        wait_rsp(r_dat, r_err, r_tmo);
        chk("rd_stb_cycles", stb_cnt, 32'd4);
        chk("rd_wb_dat_zero", last_dat, 32'h0);
        chk("rd_rsp_dat", r_dat, 32'h0012_3456);
        chk("rd_rsp_err", {31'b0, r_err}, 32'h0);
        finish_rsp(0, r_dat);

        // response backpressure for five cycles
        slv_mode = 0; slv_wait = 1; slv_rdata = 32'hCAFE_F00D;
        issue_cmd(1'b0, 4'h9, 32'h0, 4'h3);
        wait_rsp(r_dat, r_err, r_tmo);
        chk("bp_rsp_dat", r_dat, 32'hCAFE_F00D);
        chk("bp_sel", {28'b0, last_sel}, 32'h3);
        finish_rsp(5, r_dat);

        // ack and err together: err wins
        slv_mode = 2; slv_wait = 0; slv_rdata = 32'h1357_9BDF;
        issue_cmd(1'b0, 4'h2, 32'h0, 4'hF);
        wait_rsp(r_dat, r_err, r_tmo);
        chk("ae_err", {31'b0, r_err}, 32'h1);
        chk("ae_dat", r_dat, 32'h0);
        chk("ae_tmo", {31'b0, r_tmo}, 32'h0);
        finish_rsp(1, r_dat);

        // plain error on a write after two wait states
        slv_mode = 1; slv_wait = 2;
        issue_cmd(1'b1, 4'hC, 32'h8765_4321, 4'h1);
        wait_rsp(r_dat, r_err, r_tmo);
        chk("er_stb_cycles", stb_cnt, 32'd3);
        chk("er_err", {31'b0, r_err}, 32'h1);
        chk("er_dat", r_dat, 32'h0);
        finish_rsp(0, r_dat);

        // silent slave
        slv_mode = 3; slv_wait = 0;
`ifdef WB_INITIATOR_TIMEOUT_EN
        issue_cmd(1'b0, 4'h6, 32'h0, 4'hF);
        wait_rsp(r_dat, r_err, r_tmo);
        chk("to_stb_cycles", stb_cnt, TCYC);
        chk("to_err", {31'b0, r_err}, 32'h1);
        chk("to_tmo", {31'b0, r_tmo}, 32'h1);
        chk("to_dat", r_dat, 32'h0);
        finish_rsp(0, r_dat);
`else
        issue_cmd(1'b0, 4'h6, 32'h0, 4'hF);
        repeat (20) @(negedge clk);
        chk("hang_cyc", {31'b0, wb_cyc}, 32'h1);
        chk("hang_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        slv_rdata = 32'h0000_0077;
        slv_mode  = 0;
        wait_rsp(r_dat, r_err, r_tmo);
        chk("hang_dat", r_dat, 32'h0000_0077);
        chk("hang_tmo", {31'b0, r_tmo}, 32'h0);
        finish_rsp(0, r_dat);
`endif
        // late ack while idle is ignored
        slv_force_ack = 1'b1;
        repeat (3) @(negedge clk);
        slv_force_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("late_ack_valid", {31'b0, rsp_valid}, 32'h0);
        chk("late_ack_ready", {31'b0, cmd_ready}, 32'h1);

        // reset in the middle of a bus cycle
        slv_mode = 3;
        issue_cmd(1'b0, 4'hA, 32'h0, 4'hF);
        repeat (3) @(negedge clk);
        chk("mid_cyc_before", {31'b0, wb_cyc}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_cyc_async", {31'b0, wb_cyc}, 32'h0);
        chk("mid_stb_async", {31'b0, wb_stb}, 32'h0);
        chk("mid_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("mid_cmd_ready", {31'b0, cmd_ready}, 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_valid", {31'b0, rsp_valid}, 32'h0);
        slv_mode = 0; slv_wait = 1; slv_rdata = 32'hA1B2_C3D4;
        issue_cmd(1'b0, 4'h1, 32'h0, 4'hF);
        wait_rsp(r_dat, r_err, r_tmo);
        chk("post_rst_dat", r_dat, 32'hA1B2_C3D4);
        chk("post_rst_err", {31'b0, r_err}, 32'h0);
        finish_rsp(0, r_dat);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Global bound so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/wb_initiator.md
# wb_initiator

Single-outstanding Wishbone classic-cycle master that converts a valid/ready command stream into bus transactions and returns a valid/ready response stream. It sits between a test or control source (UVC driver shim, boot sequencer, debug bridge) and Wishbone peripherals such as the GPIO block. It owns the initiator side of the handshake: `wb_cyc_o`/`wb_stb_o` generation, ack/err termination, read-data capture and bus-hang protection.

## Interface
- `AW`, default 4: Wishbone address width.
- `TIMEOUT_CYC`, default 255: maximum cycles `wb_stb_o` stays asserted without termination; must be in the range 2..65535.
- `wb_clk_i` in 1: clock; all logic on rising edge.
- `wb_rst_ni` in 1: reset, asynchronous assert, active-low; one clock, reset is asynchronous and active-low.
- `cmd_valid_i` in 1: command present.
- `cmd_ready_o` out 1: command accepted this cycle when high with `cmd_valid_i`.
- `cmd_we_i` in 1: 1 = write, 0 = read.
- `cmd_adr_i` in AW: target address.
- `cmd_dat_i` in 32: write data.
- `cmd_sel_i` in 4: byte selects.
- `rsp_valid_o` out 1: response present.
- `rsp_ready_i` in 1: response consumed.
- `rsp_dat_o` out 32: read data; 0 for writes and errors.
- `rsp_err_o` out 1: transaction ended with `wb_err_i` or timeout.
- `rsp_tmo_o` out 1: transaction ended by timeout.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o` out 1: Wishbone controls.
- `wb_adr_o` out AW; `wb_dat_o` out 32; `wb_sel_o` out 4: Wishbone address, data and byte selects.
- `wb_dat_i` in 32; `wb_ack_i` in 1; `wb_err_i` in 1: slave response.

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE: `cmd_ready_o` = 1. On `cmd_valid_i`, register we/adr/dat/sel and move to BUS.
- BUS:
  - `wb_cyc_o` = `wb_stb_o` = 1. `wb_we_o`, `wb_adr_o`, `wb_dat_o` and `wb_sel_o` are driven from the registered command and are stable for the whole state.
  - On a sampled `wb_ack_i` or `wb_err_i`, move to RESP.
  - On ack with a read, capture `wb_dat_i` into `rsp_dat_o`.
  - `rsp_err_o` = `wb_err_i`.
- Simultaneous ack and err: err wins. `rsp_err_o` = 1 and `rsp_dat_o` = 0.
- RESP: `rsp_valid_o` = 1 and the response fields are held stable. When `rsp_ready_i` = 1, move to IDLE.
- `wb_ack_i`/`wb_err_i` seen in IDLE or RESP are ignored.
- `wb_dat_o` is 0 during reads.
- Only one transaction is outstanding at a time. `cmd_ready_o` is low in BUS and RESP.
- Asynchronous reset at any point:
  - FSM returns to IDLE.
  - All outputs take their reset values; any in-flight cycle is abandoned with no response.
- Reset values:
  - `cmd_ready_o` = 1 (combinational from IDLE).
  - All other outputs = 0.

## Timing
- Command accepted at edge N. `wb_cyc_o`/`wb_stb_o` are high from edge N through at least edge N+1; all Wishbone outputs are registered.
- Termination sampled at edge N+k (k ≥ 1):
  - `wb_cyc_o`/`wb_stb_o` are low after edge N+k.
  - `rsp_valid_o` is high after edge N+k.
- With a zero-wait slave (combinational ack), the minimum command-to-response latency is 1 cycle after acceptance.
- Throughput is at most one transaction per 3 cycles (IDLE, BUS, RESP), with `rsp_ready_i` tied high.
- `rsp_valid_o` is never low while a response is pending and `rsp_ready_i` = 0.

## Configuration
- Macro `WB_INITIATOR_TIMEOUT_EN`.
- Defined:
  - A 16-bit counter clears on entry to BUS and increments every BUS cycle.
  - If it reaches `TIMEOUT_CYC` with no ack/err sampled, the FSM moves to RESP with `rsp_err_o` = 1, `rsp_tmo_o` = 1 and `rsp_dat_o` = 0.
  - An ack or err on the same edge as the timeout wins over the timeout.
- Undefined:
  - No counter is built; BUS waits indefinitely.
  - `rsp_tmo_o` is tied to 0.

## Test plan
- Write: cmd we=1, adr=0x4, dat=0x0000_00A5, sel=0xF; slave acks on the first cycle.
  - Exactly one cycle with `wb_cyc_o`/`wb_stb_o`/`wb_we_o` high, `wb_adr_o`=0x4 and `wb_dat_o`=0xA5.
  - Then `rsp_valid_o`=1 with err=0 and dat=0.
- Read with 3 wait states: cmd we=0, adr=0x0; slave acks after 3 cycles with `wb_dat_i`=0x0012_3456.
  - `wb_stb_o` is high for 4 cycles.
  - Response dat=0x0012_3456, err=0.
- Response backpressure:
  - `rsp_ready_i` held 0 for 5 cycles: `rsp_valid_o` and data are held stable and `cmd_ready_o` stays 0.
  - `cmd_ready_o` returns to 1 the cycle after the response handshake.
- Error priority: `wb_ack_i` and `wb_err_i` asserted together → `rsp_err_o`=1, `rsp_dat_o`=0, `rsp_tmo_o`=0.
- Timeout: with the macro defined and `TIMEOUT_CYC`=8, the slave never responds.
  - Cycle drops after 8 cycles.
  - Response err=1, tmo=1.
  - A late `wb_ack_i` afterwards is ignored.
- Reset mid-cycle: `wb_rst_ni` asserted low while in BUS.
  - `wb_cyc_o`/`wb_stb_o` drop asynchronously and `rsp_valid_o` stays 0.
  - After release, `cmd_ready_o`=1 and a new read completes normally.
